// File: rtl/eth_rx_dma_pkg.sv
// Shared types and AHB-lite constants for the Ethernet RX DMA master.
// Offsets are relative to the Ethernet slave base address.
package eth_dma_pkg;

  typedef enum logic [2:0] {IDLE, CLR, RD, WR, ACK, DONE} dma_state_e;
  typedef enum logic [1:0] {XF_IDLE, XF_ADDR, XF_DATA} xfer_state_e;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HSIZE_WORD    = 3'b010;
  localparam logic [1:0]  HRESP_ERROR   = 2'b01;

  localparam logic [31:0] INTCLR_OFF    = 32'h0;
  localparam logic [31:0] TXOK_OFF      = 32'h4;

endpackage

// File: rtl/eth_rx_dma_if.sv
// AHB-lite master bus of the RX DMA; the master modport drives the
// address/control/write-data pins, the slave modport returns data and status.
interface eth_rx_dma_if;
  logic [31:0] m_haddr;
  logic [1:0]  m_htrans;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [31:0] m_hwdata;
  logic [31:0] m_hrdata;
  logic        m_hready;
  logic [1:0]  m_hresp;

  modport master (
    output m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata,
    input  m_hrdata, m_hready, m_hresp
  );

  modport slave (
    input  m_haddr, m_htrans, m_hwrite, m_hsize, m_hwdata,
    output m_hrdata, m_hready, m_hresp
  );
endinterface

// File: rtl/eth_rx_dma_xfer.sv
// Single non-pipelined AHB-lite transfer engine. addr_i/wr_i are taken with
// start_i; wdata_i is sampled when the address phase is accepted.
module ahb_single_xfer
  import eth_dma_pkg::*;
(
  input  logic         hclk,
  input  logic         hrst_b,
  eth_rx_dma_if.master bus,
  input  logic         start_i,
  input  logic [31:0]  addr_i,
  input  logic         wr_i,
  input  logic [31:0]  wdata_i,
  output logic         done_o,
  output logic [31:0]  rdata_o,
  output logic         err_o
);

  xfer_state_e st_q;
  logic [31:0] haddr_q;
  logic [31:0] hwdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic        data_end;

  assign data_end = (st_q == XF_DATA) && bus.m_hready;
  assign done_o   = data_end;
  assign err_o    = data_end && (bus.m_hresp == HRESP_ERROR);
  assign rdata_o  = rdata_q;

  assign bus.m_haddr  = haddr_q;
  assign bus.m_htrans = htrans_q;
  assign bus.m_hwrite = hwrite_q;
  assign bus.m_hsize  = HSIZE_WORD;
  assign bus.m_hwdata = hwdata_q;

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      st_q     <= XF_IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
    end else begin
      case (st_q)
        XF_ADDR: begin
          if (bus.m_hready) begin
            st_q     <= XF_DATA;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= wdata_i;
          end
        end
        XF_DATA: begin
          if (bus.m_hready) begin
            if (!hwrite_q) rdata_q <= bus.m_hrdata;
            st_q <= XF_IDLE;
          end
        end
        default: ;
      endcase
      // A new address phase may follow the completing data phase directly.
      if (start_i && ((st_q == XF_IDLE) || data_end)) begin
        st_q     <= XF_ADDR;
        htrans_q <= HTRANS_NONSEQ;
        haddr_q  <= addr_i;
        hwrite_q <= wr_i;
      end
    end
  end

endmodule

// File: rtl/eth_rx_dma.sv
// Ethernet RX DMA: per frame clears the slave interrupt, copies BURST_WORDS
// FIFO words into SRAM, then writes DMACTRANOK.
//
// state | meaning
// IDLE  | waiting for enable & eth_intr
// CLR   | write 0 to INTCLEAR
// RD    | read one word from the RX FIFO
// WR    | write that word to DST_BASE + 4*word_idx
// ACK   | write 1 to DMACTRANOK
// DONE  | frame_done pulse, frame_cnt incremented
module eth_rx_dma
  import eth_dma_pkg::*;
#(
  parameter logic [31:0] ETH_BASE    = 32'h4000_0000,
  parameter logic [31:0] DST_BASE    = 32'h2000_0000,
  parameter int          BURST_WORDS = 256
)(
  input  logic         hclk,
  input  logic         hrst_b,
  input  logic         enable,
  input  logic         eth_intr,
  eth_rx_dma_if.master m,
  output logic         busy,
  output logic         frame_done,
  output logic         dma_err,
  output logic [15:0]  frame_cnt
);

  localparam int               IDX_W    = $clog2(BURST_WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_WORDS - 1);

  dma_state_e       st_q, st_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, frame_done_q, dma_err_q;
  logic [15:0]      frame_cnt_q;

  logic        x_start, x_wr, x_done, x_err;
  logic [31:0] x_addr, x_wdata, x_rdata;

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    x_start = 1'b0;
    case (st_q)
      IDLE: if (enable && eth_intr) begin
        st_d    = CLR;
        idx_d   = '0;
        x_start = 1'b1;
      end
      CLR: if (x_done) begin
        st_d    = RD;
        x_start = 1'b1;
      end
      RD: if (x_done) begin
        st_d    = WR;
        x_start = 1'b1;
      end
      WR: if (x_done) begin
        idx_d   = idx_q + IDX_W'(1);
        st_d    = (idx_q < LAST_IDX) ? RD : ACK;
        x_start = 1'b1;
      end
      ACK:     if (x_done) st_d = DONE;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
    // An ERROR response abandons the frame without acking the slave.
    if (x_err) begin
      st_d    = IDLE;
      x_start = 1'b0;
    end
  end

  // Address/direction belong to the transfer being launched (st_d);
  // write data is consumed during its address phase (st_q).
  always_comb begin
    x_addr = ETH_BASE + INTCLR_OFF;
    x_wr   = 1'b0;
    case (st_d)
      CLR: x_wr = 1'b1;
      WR: begin
        x_addr = DST_BASE + (32'(idx_q) << 2);
        x_wr   = 1'b1;
      end
      ACK: begin
        x_addr = ETH_BASE + TXOK_OFF;
        x_wr   = 1'b1;
      end
      default: ;
    endcase
    case (st_q)
      WR:      x_wdata = x_rdata;
      ACK:     x_wdata = 32'h1;
      default: x_wdata = '0;
    endcase
  end

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      st_q         <= IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dma_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      st_q         <= st_d;
      idx_q        <= idx_d;
      busy_q       <= (st_d != IDLE);
      frame_done_q <= (st_d == DONE);
      if ((st_q == ACK) && (st_d == DONE)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((st_q == IDLE) && (st_d == CLR)) dma_err_q <= 1'b0;
      else if (x_err)                      dma_err_q <= 1'b1;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dma_err    = dma_err_q;
  assign frame_cnt  = frame_cnt_q;

  ahb_single_xfer u_xfer (
    .hclk    (hclk),
    .hrst_b  (hrst_b),
    .bus     (m),
    .start_i (x_start),
    .addr_i  (x_addr),
    .wr_i    (x_wr),
    .wdata_i (x_wdata),
    .done_o  (x_done),
    .rdata_o (x_rdata),
    .err_o   (x_err)
  );

endmodule

// File: tb/tb_eth_rx_dma.sv
// Scoreboard bench for eth_rx_dma with BURST_WORDS=4 and a behavioural
// Ethernet slave that returns 0xA0.. and clears its interrupt on INTCLEAR.
module tb_eth_rx_dma;

  localparam int          BW  = 4;
  localparam logic [31:0] ETH = 32'h4000_0000;
  localparam logic [31:0] DST = 32'h2000_0000;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hrst_b;
  logic        enable;
  logic        eth_intr;
  logic        busy, frame_done, dma_err;
  logic [15:0] frame_cnt;

  eth_rx_dma_if m_if ();

  eth_rx_dma #(.ETH_BASE(ETH), .DST_BASE(DST), .BURST_WORDS(BW)) dut (
    .hclk       (hclk),
    .hrst_b     (hrst_b),
    .enable     (enable),
    .eth_intr   (eth_intr),
    .m          (m_if),
    .busy       (busy),
    .frame_done (frame_done),
    .dma_err    (dma_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 hclk = ~hclk;

  int    vectors = 0;
  int    miscompares = 0;
  xfer_t exp_q[$];
  int    fc_q[$];

  // slave model state
  bit          dp, was_dp, err_now;
  int          wait_left, rd_idx;
  int          n_wait = 0;
  int          err_rd = -1;
  int          raise_cnt = 0, raise_seen = 0;
  logic [31:0] cur_addr;
  logic        cur_wr;
  xfer_t       got_e;
  int          fc_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired, got timeout expected event", name);
  endtask

  task automatic push_x(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.data = data;
    exp_q.push_back(x);
  endtask

  task automatic push_frame(input int fc);
    push_x(1'b1, ETH, 32'h0);
    for (int i = 0; i < BW; i++) begin
      push_x(1'b0, ETH, 32'h0);
      push_x(1'b1, DST + 32'(4 * i), 32'hA0 + 32'(i));
    end
    push_x(1'b1, ETH + 32'h4, 32'h1);
    if (fc >= 0) fc_q.push_back(fc);
  endtask

  // Returns at posedge+1 once busy has fallen; cyc counts clock edges.
  task automatic run_frame(input string name, input int max, output int cyc);
    cyc = 0;
    do begin
      @(posedge hclk); #1;
      cyc++;
    end while (busy && cyc < max);
    if (busy) timeout(name);
  endtask

  // eth_intr rises at the next negedge; returns at negedge+1 with it high.
  task automatic raise_intr();
    @(negedge hclk); #1;
    raise_cnt++;
    @(negedge hclk); #1;
  endtask

  task automatic wait_wr_dp(input string name, input logic [31:0] addr);
    int n = 0;
    do begin
      @(negedge hclk); #1;
      n++;
    end while (!(dp && cur_wr && cur_addr == addr) && n < 300);
    if (n >= 300) timeout(name);
  endtask

  // Ethernet slave + transfer monitor; all slave outputs change on negedge.
  always @(negedge hclk) begin
    if (!hrst_b) begin
      dp = 0; wait_left = 0; rd_idx = 0; eth_intr = 1'b0;
      m_if.m_hready = 1'b1; m_if.m_hresp = 2'b00; m_if.m_hrdata = '0;
      raise_seen = raise_cnt;
    end else begin
      if (raise_cnt != raise_seen) begin
        eth_intr = 1'b1;
        raise_seen = raise_cnt;
      end
      was_dp = dp;
      if (dp) begin
        check("dp_htrans", 32'(m_if.m_htrans), 32'h0);
        check("dp_haddr", m_if.m_haddr, cur_addr);
        if (wait_left > 0) begin
          m_if.m_hresp  = (err_now && wait_left == 1) ? 2'b01 : 2'b00;
          m_if.m_hready = 1'b0;
          wait_left--;
        end else begin
          m_if.m_hready = 1'b1;
          m_if.m_hresp  = err_now ? 2'b01 : 2'b00;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_extra: got wr=%0d addr %h expected no transfer", cur_wr, cur_addr);
          end else begin
            got_e = exp_q.pop_front();
            check("xfer_wr", 32'(cur_wr), 32'(got_e.wr));
            check("xfer_addr", cur_addr, got_e.addr);
            if (got_e.wr) check("xfer_wdata", m_if.m_hwdata, got_e.data);
          end
          if (!cur_wr) rd_idx++;
          if (cur_wr && cur_addr == ETH) begin
            eth_intr = 1'b0;
            rd_idx = 0;
          end
          dp = 0;
        end
      end else begin
        m_if.m_hready = 1'b1;
        m_if.m_hresp  = 2'b00;
      end
      if (!was_dp && m_if.m_htrans == 2'b10) begin
        dp = 1;
        cur_addr = m_if.m_haddr;
        cur_wr   = m_if.m_hwrite;
        err_now  = !m_if.m_hwrite && (rd_idx == err_rd);
        wait_left = n_wait + (err_now ? 1 : 0);
        if (!m_if.m_hwrite) m_if.m_hrdata = 32'hA0 + 32'(rd_idx);
      end
    end
  end

  always @(posedge hclk) begin
    #1;
    if (hrst_b && frame_done) begin
      if (fc_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_done: got pulse with frame_cnt %0d expected none", frame_cnt);
      end else begin
        fc_e = fc_q.pop_front();
        check("frame_cnt_at_done", 32'(frame_cnt), 32'(fc_e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    hrst_b = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    check("rst_htrans", 32'(m_if.m_htrans), 32'h0);
    check("rst_haddr", m_if.m_haddr, 32'h0);
    check("rst_hwrite", 32'(m_if.m_hwrite), 32'h0);
    check("rst_hwdata", m_if.m_hwdata, 32'h0);
    check("rst_hsize", 32'(m_if.m_hsize), 32'h2);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_flags", {29'h0, frame_done, dma_err, 1'b0}, 32'h0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    @(negedge hclk);
    hrst_b = 1'b1;
    enable = 1'b1;

    // zero-wait frame
    push_frame(1);
    raise_intr();
    run_frame("t1_frame", 200, cyc);
    check("t1_cycles", cyc, 22);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_drained", exp_q.size(), 0);

    // three wait states per data phase
    n_wait = 3;
    push_frame(2);
    raise_intr();
    run_frame("t2_frame", 300, cyc);
    check("t2_cycles", cyc, 52);
    check("t2_drained", exp_q.size(), 0);
    n_wait = 0;

    // ERROR on the second read, then a clean frame
    err_rd = 1;
    push_x(1'b1, ETH, 32'h0);
    push_x(1'b0, ETH, 32'h0);
    push_x(1'b1, DST, 32'hA0);
    push_x(1'b0, ETH, 32'h0);
    raise_intr();
    run_frame("t3_err_frame", 200, cyc);
    check("t3_dma_err", 32'(dma_err), 32'h1);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd2);
    check("t3_drained", exp_q.size(), 0);
    err_rd = -1;
    push_frame(3);
    raise_intr();
    @(posedge hclk); #1;
    check("t3_err_cleared", 32'(dma_err), 32'h0);
    run_frame("t3_retry", 200, cyc);
    check("t3_retry_cnt", 32'(frame_cnt), 32'd3);

    // eth_intr re-asserted mid-frame: back-to-back frames
    push_frame(4);
    push_frame(5);
    raise_intr();
    n = 0;
    while (eth_intr && n < 100) begin @(negedge hclk); #1; n++; end
    if (n >= 100) timeout("t4_intr_clear");
    repeat (2) @(negedge hclk);
    raise_intr();
    n = 0;
    do begin @(posedge hclk); #1; n++; end while (!frame_done && n < 200);
    if (!frame_done) timeout("t4_first_done");
    @(posedge hclk); #1;
    check("t4_idle_gap", 32'(busy), 32'h0);
    @(posedge hclk); #1;
    check("t4_restart_busy", 32'(busy), 32'h1);
    check("t4_restart_htrans", 32'(m_if.m_htrans), 32'h2);
    check("t4_restart_haddr", m_if.m_haddr, ETH);
    run_frame("t4_second", 200, cyc);
    check("t4_frame_cnt", 32'(frame_cnt), 32'd5);

    // enable dropped during word 2
    push_frame(6);
    raise_intr();
    wait_wr_dp("t5_word2", DST + 32'h4);
    enable = 1'b0;
    run_frame("t5_frame", 200, cyc);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd6);
    check("t5_drained", exp_q.size(), 0);
    raise_intr();
    repeat (5) @(posedge hclk);
    #1;
    check("t5_no_start", 32'(busy), 32'h0);

    // async reset during a WR data phase
    push_frame(-1);
    @(negedge hclk);
    enable = 1'b1;
    wait_wr_dp("t6_wr_phase", DST);
    #1 hrst_b = 1'b0;
    #1;
    check("t6_htrans", 32'(m_if.m_htrans), 32'h0);
    check("t6_haddr", m_if.m_haddr, 32'h0);
    check("t6_hwrite", 32'(m_if.m_hwrite), 32'h0);
    check("t6_hwdata", m_if.m_hwdata, 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_flags", {30'h0, frame_done, dma_err}, 32'h0);
    check("t6_frame_cnt", 32'(frame_cnt), 32'h0);
    exp_q.delete();
    @(negedge hclk);
    #2 hrst_b = 1'b1;
    @(posedge hclk); #1;
    check("t6_post_htrans", 32'(m_if.m_htrans), 32'h0);
    check("t6_post_busy", 32'(busy), 32'h0);

    repeat (3) @(posedge hclk);
    #1;
    check("end_xfers_left", exp_q.size(), 0);
    check("end_frames_left", fc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
